nanodmem_io: RTL and testbench

- Data-side memory subsystem directly downstream of the nanoCPU data port; consumes d_address, d_data and mem_wr.
- Decodes each access to either a word-addressed RAM or a memory-mapped I/O page.
- The I/O page holds an LED output register, a synchronised switch input, and a compare/match timer with an interrupt output.
- Reads are combinational, so the CPU completes a load in the same cycle. Writes commit on the clock edge.

---
 rtl/nanolada_io_pkg.sv | 18 +
 rtl/nanotimer.sv | 79 +++++++
 rtl/nanodmem_io.sv | 84 ++++++++
 tb/tb_nanodmem_io.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/nanolada_io_pkg.sv
// Shared definitions for the nanoCPU data-side I/O page: register offsets,
// timer control bit positions and the default page select value.
package nanolada_io_pkg;

    localparam logic [3:0] IO_PAGE_DEF = 4'hF;

    localparam logic [2:0] IO_LED  = 3'd0;
    localparam logic [2:0] IO_SW   = 3'd1;
    localparam logic [2:0] IO_CNT  = 3'd2;
    localparam logic [2:0] IO_CMP  = 3'd3;
    localparam logic [2:0] IO_CTRL = 3'd4;
    localparam logic [2:0] IO_STAT = 3'd5;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_ARL = 1;
    localparam int CTRL_IRQ = 2;

endpackage

// File: rtl/nanotimer.sv
// Compare/match timer: COUNT, COMPARE, CTRL and STATUS registers with
// write-collision priority and a registered level interrupt.
module nanotimer
    import nanolada_io_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        wr_i,
    input  logic [2:0]  off_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             match_q, match_d;
    logic             irq_q, irq_d;
    logic             hit;

    always_comb begin
        count_d = count_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        match_d = match_q;
        hit     = ctrl_q[CTRL_EN] && (count_q == cmp_q);

        if (ctrl_q[CTRL_EN]) begin
            count_d = (hit && ctrl_q[CTRL_ARL]) ? '0 : count_q + CNT_W'(1);
        end

        if (wr_i) begin
            case (off_i)
                IO_CNT:  count_d = wdata_i[CNT_W-1:0];
                IO_CMP:  cmp_d   = wdata_i[CNT_W-1:0];
                IO_CTRL: ctrl_d  = wdata_i[2:0];
                IO_STAT: if (wdata_i[0]) match_d = 1'b0;
                default: ;
            endcase
        end

        // A match on this edge outranks a simultaneous clear.
        if (hit) match_d = 1'b1;

        irq_d = match_d & ctrl_d[CTRL_IRQ];
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            count_q <= '0;
            cmp_q   <= '1;
            ctrl_q  <= '0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            match_q <= match_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        case (off_i)
            IO_CNT:  rdata_o = 32'(count_q);
            IO_CMP:  rdata_o = 32'(cmp_q);
            IO_CTRL: rdata_o = {29'd0, ctrl_q};
            IO_STAT: rdata_o = {31'd0, match_q};
            default: rdata_o = '0;
        endcase
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/nanodmem_io.sv
// nanoCPU data-port memory: word RAM plus an I/O page (LED, synchronised
// switches, timer). Reads are combinational; writes commit on the clock edge.
module nanodmem_io
    import nanolada_io_pkg::*;
#(
    parameter int         RAM_AW  = 10,
    parameter logic [3:0] IO_PAGE = IO_PAGE_DEF,
    parameter int         CNT_W   = 32
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic [31:0] d_address,
    inout  logic [31:0] d_data,
    input  logic        mem_wr,
    input  logic [31:0] sw_in,
    output logic [31:0] led_out,
    output logic        irq
);

    logic [31:0]       ram_q [0:(1<<RAM_AW)-1];
    logic [31:0]       led_q;
    logic [31:0]       sync1_q;
    logic [31:0]       sync2_q;
    logic              io_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic [2:0]        io_off;
    logic [31:0]       tmr_rdata;
    logic [31:0]       rdata;
    logic              unused_addr_bits;

    assign io_sel  = (d_address[31:28] == IO_PAGE);
    assign ram_idx = d_address[RAM_AW+1:2];
    assign io_off  = d_address[4:2];
    assign unused_addr_bits = ^{d_address[27:RAM_AW+2], d_address[1:0]};

    // RAM contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (nreset && mem_wr && !io_sel) begin
            ram_q[ram_idx] <= d_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            led_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
            if (mem_wr && io_sel && (io_off == IO_LED)) begin
                led_q <= d_data;
            end
        end
    end

    nanotimer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock   (clock),
        .nreset  (nreset),
        .wr_i    (mem_wr && io_sel),
        .off_i   (io_off),
        .wdata_i (d_data),
        .rdata_o (tmr_rdata),
        .irq_o   (irq)
    );

    always_comb begin
        if (io_sel) begin
            case (io_off)
                IO_LED:  rdata = led_q;
                IO_SW:   rdata = sync2_q;
                default: rdata = tmr_rdata;
            endcase
        end else begin
            rdata = ram_q[ram_idx];
        end
    end

    assign d_data  = mem_wr ? 32'bz : rdata;
    assign led_out = led_q;

endmodule

// File: tb/tb_nanodmem_io.sv
// Directed bench for nanodmem_io: RAM aliasing, LED/switch I/O, timer match,
// auto-reload collisions and mid-run reset.
module tb_nanodmem_io;

    localparam logic [31:0] A_LED  = 32'hF000_0000;
    localparam logic [31:0] A_SW   = 32'hF000_0004;
    localparam logic [31:0] A_CNT  = 32'hF000_0008;
    localparam logic [31:0] A_CMP  = 32'hF000_000C;
    localparam logic [31:0] A_CTRL = 32'hF000_0010;
    localparam logic [31:0] A_STAT = 32'hF000_0014;
    localparam logic [31:0] A_OFF6 = 32'hF000_0018;
    localparam logic [31:0] A_OFF7 = 32'hF000_001C;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic [31:0] d_address = '0;
    logic        mem_wr = 1'b0;
    logic [31:0] tb_data = '0;
    logic [31:0] sw_in = '0;
    logic [31:0] led_out;
    logic        irq;
    wire  [31:0] d_data;

    int vectors = 0;
    int miscompares = 0;

    assign d_data = mem_wr ? tb_data : 32'bz;

    always #50 clock = ~clock;

    nanodmem_io dut (
        .clock     (clock),
        .nreset    (nreset),
        .d_address (d_address),
        .d_data    (d_data),
        .mem_wr    (mem_wr),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
        d_address = a;
        tb_data   = v;
        mem_wr    = 1'b1;
        @(posedge clock);
        #1;
        mem_wr    = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        mem_wr    = 1'b0;
        d_address = a;
        #1;
        check(tag, d_data, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        nreset = 1'b1;

        check("rst_led", led_out, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        rd_check("rst_cmp", A_CMP, 32'hFFFF_FFFF);
        rd_check("rst_cnt", A_CNT, 32'h0);
        rd_check("rst_ctrl", A_CTRL, 32'h0);
        rd_check("rst_stat", A_STAT, 32'h0);
        rd_check("rst_sw", A_SW, 32'h0);

        bus_wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd_check("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        rd_check("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
        bus_wr(32'h0000_0014, 32'h1111_2222);
        rd_check("ram_rd2", 32'h0000_0014, 32'h1111_2222);
        rd_check("ram_keep", 32'h0000_0010, 32'hDEAD_BEEF);

        bus_wr(A_LED, 32'h0000_00A5);
        check("led_out", led_out, 32'h0000_00A5);
        rd_check("led_rd", A_LED, 32'h0000_00A5);
        rd_check("off6_rd", A_OFF6, 32'h0);
        bus_wr(A_OFF7, 32'hFFFF_FFFF);
        rd_check("off7_ignored", A_OFF7, 32'h0);
        d_address = A_LED;
        tb_data   = 32'h1234_5678;
        mem_wr    = 1'b1;
        #1;
        check("bus_release", d_data, 32'h1234_5678);
        mem_wr    = 1'b0;
        bus_wr(A_SW, 32'hFFFF_FFFF);
        rd_check("sw_ro", A_SW, 32'h0);

        sw_in = 32'h0000_1234;
        tick();
        rd_check("sw_sync_e", A_SW, 32'h0);
        tick();
        rd_check("sw_sync_e1", A_SW, 32'h0000_1234);

        bus_wr(A_CMP, 32'd5);
        bus_wr(A_CTRL, 32'h5);
        rd_check("cnt_n", A_CNT, 32'd0);
        repeat (5) tick();
        rd_check("cnt_n5", A_CNT, 32'd5);
        rd_check("stat_n5", A_STAT, 32'd0);
        check("irq_n5", {31'd0, irq}, 32'd0);
        tick();
        rd_check("stat_n6", A_STAT, 32'd1);
        check("irq_n6", {31'd0, irq}, 32'd1);
        rd_check("cnt_n6", A_CNT, 32'd6);
        bus_wr(A_STAT, 32'd1);
        rd_check("stat_w1c", A_STAT, 32'd0);
        check("irq_w1c", {31'd0, irq}, 32'd0);
        rd_check("cnt_n7", A_CNT, 32'd7);

        bus_wr(A_CTRL, 32'h0);
        rd_check("ctrl_late", A_CNT, 32'd8);
        repeat (2) tick();
        rd_check("cnt_hold", A_CNT, 32'd8);

        bus_wr(A_CNT, 32'd0);
        bus_wr(A_CMP, 32'd3);
        bus_wr(A_CTRL, 32'h3);
        rd_check("arl_c0", A_CNT, 32'd0);
        rd_check("ctrl_rd", A_CTRL, 32'h3);
        tick();
        rd_check("arl_c1", A_CNT, 32'd1);
        tick();
        rd_check("arl_c2", A_CNT, 32'd2);
        tick();
        rd_check("arl_c3", A_CNT, 32'd3);
        bus_wr(A_STAT, 32'd1);
        rd_check("arl_reload", A_CNT, 32'd0);
        rd_check("w1c_collide", A_STAT, 32'd1);
        check("irq_disabled", {31'd0, irq}, 32'd0);
        bus_wr(A_STAT, 32'd1);
        rd_check("stat_clr", A_STAT, 32'd0);
        repeat (2) tick();
        rd_check("arl_c3b", A_CNT, 32'd3);
        bus_wr(A_CNT, 32'd100);
        rd_check("cnt_wr_wins", A_CNT, 32'd100);
        rd_check("match_on_wr", A_STAT, 32'd1);

        bus_wr(A_CTRL, 32'h0);
        bus_wr(A_STAT, 32'd1);
        bus_wr(A_CMP, 32'd6);
        bus_wr(A_CNT, 32'd6);
        bus_wr(A_LED, 32'h0000_00FF);
        bus_wr(32'h0000_0010, 32'h0000_0055);
        bus_wr(A_CTRL, 32'h5);
        tick();
        rd_check("pre_cnt", A_CNT, 32'd7);
        check("pre_irq", {31'd0, irq}, 32'd1);
        check("pre_led", led_out, 32'h0000_00FF);

        nreset = 1'b0;
        bus_wr(A_LED, 32'h0000_0077);
        rd_check("rst_rd_live", 32'h0000_0010, 32'h0000_0055);
        nreset = 1'b1;
        rd_check("mr_cnt", A_CNT, 32'd0);
        rd_check("mr_cmp", A_CMP, 32'hFFFF_FFFF);
        check("mr_led", led_out, 32'h0);
        check("mr_irq", {31'd0, irq}, 32'd0);
        rd_check("mr_sw", A_SW, 32'h0);
        rd_check("mr_ctrl", A_CTRL, 32'h0);
        rd_check("mr_stat", A_STAT, 32'h0);
        rd_check("mr_ram", 32'h0000_0010, 32'h0000_0055);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
